// File: rtl/flash_read_sequencer.sv
// Flash READ sequencer: owns the shared SPI byte engine during a read burst
// and parks CPU byte transfers in a single slot until the burst has finished.
module flash_read_sequencer #(
    parameter logic [7:0]  READ_CMD = 8'h03,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] flash_addr,
    input  logic [15:0] len,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ack,
    input  logic        cpu_cs_n,
    input  logic        cpu_xfer_req,
    input  logic [7:0]  cpu_tx,
    output logic        cpu_wait_n,
    output logic        spi_cs_n,
    output logic        xfer_start,
    output logic [7:0]  xfer_tx,
    input  logic        xfer_done,
    input  logic [7:0]  xfer_rx
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_A2, S_A1, S_A0, S_DATA, S_HOLD, S_GAP
    } state_t;

    state_t      state, state_d;
    logic [23:0] addr_q;
    logic [15:0] remain_q;
    logic [3:0]  gap_q;
    logic        abort_q, aborted_q;
    logic        seq_start_q;
    logic [7:0]  seq_tx_q;
    logic        dv_q;
    logic [7:0]  dout_q;
    logic        pend_valid_q, pend_issued_q, pend_fire_q;
    logic [7:0]  pend_tx_q;

    logic        accept, aborting, in_xfer, issue, capture, go_abort;
    logic [7:0]  tx_d;

    assign accept   = (state == S_IDLE) && start && cpu_cs_n && !pend_valid_q;
    assign aborting = abort_q || abort;
    assign in_xfer  = (state == S_CMD) || (state == S_A2) || (state == S_A1) ||
                      (state == S_A0)  || (state == S_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d  = state;
        issue    = 1'b0;
        capture  = 1'b0;
        go_abort = 1'b0;
        tx_d     = seq_tx_q;
        case (state)
            S_IDLE: if (accept) begin
                if (len == '0) begin
                    state_d = S_GAP;
                end else begin
                    state_d = S_CMD;
                    issue   = 1'b1;
                    tx_d    = READ_CMD;
                end
            end
            S_CMD, S_A2, S_A1, S_A0: if (xfer_done) begin
                if (aborting) begin
                    state_d  = S_GAP;
                    go_abort = 1'b1;
                end else begin
                    issue = 1'b1;
                    case (state)
                        S_CMD:   begin state_d = S_A2;   tx_d = addr_q[23:16]; end
                        S_A2:    begin state_d = S_A1;   tx_d = addr_q[15:8];  end
                        S_A1:    begin state_d = S_A0;   tx_d = addr_q[7:0];   end
                        default: begin state_d = S_DATA; tx_d = 8'hFF;         end
                    endcase
                end
            end
            S_DATA: if (xfer_done) begin
                state_d = S_GAP;
                if (aborting) begin
                    go_abort = 1'b1;
                end else begin
                    state_d = S_HOLD;
                    capture = 1'b1;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d  = S_GAP;
                    go_abort = 1'b1;
                end else if (data_ack) begin
                    // remain_q is the count before this ack's decrement
                    if (remain_q != 16'd1) begin
                        state_d = S_DATA;
                        issue   = 1'b1;
                        tx_d    = 8'hFF;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: if (gap_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            remain_q    <= '0;
            gap_q       <= '0;
            abort_q     <= 1'b0;
            aborted_q   <= 1'b0;
            seq_start_q <= 1'b0;
            seq_tx_q    <= 8'hFF;
            dv_q        <= 1'b0;
            dout_q      <= '0;
        end else begin
            seq_start_q <= issue;
            seq_tx_q    <= tx_d;
            if (accept) begin
                addr_q   <= flash_addr;
                remain_q <= len;
            end else if (state == S_HOLD && !abort && data_ack) begin
                remain_q <= remain_q - 16'd1;
            end
            // A zero-length request spends a single GAP cycle so busy lasts one cycle
            if (state_d == S_GAP && state != S_GAP)
                gap_q <= (state == S_IDLE) ? '0 : 4'(CS_GAP - 1);
            else if (state == S_GAP && gap_q != '0)
                gap_q <= gap_q - 4'd1;
            if (accept || state_d == S_GAP)    abort_q <= 1'b0;
            else if (abort && in_xfer)         abort_q <= 1'b1;
            if (accept)        aborted_q <= 1'b0;
            else if (go_abort) aborted_q <= 1'b1;
            if (capture) begin
                dout_q <= xfer_rx;
                dv_q   <= 1'b1;
            end else if (state == S_HOLD && state_d != S_HOLD) begin
                dv_q <= 1'b0;
            end
        end
    end

    // Pending CPU slot: fires the cycle after busy falls, released by its xfer_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q  <= 1'b0;
            pend_issued_q <= 1'b0;
            pend_fire_q   <= 1'b0;
            pend_tx_q     <= 8'hFF;
        end else begin
            pend_fire_q <= (state == S_IDLE) && pend_valid_q && !pend_issued_q && !pend_fire_q;
            if (busy && cpu_xfer_req) begin
                pend_valid_q  <= 1'b1;
                pend_issued_q <= 1'b0;
                pend_tx_q     <= cpu_tx;
            end else if (pend_fire_q) begin
                pend_issued_q <= 1'b1;
            end else if (pend_issued_q && xfer_done) begin
                pend_valid_q  <= 1'b0;
                pend_issued_q <= 1'b0;
            end
        end
    end

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_GAP) && (gap_q == '0);
    assign aborted    = aborted_q;
    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign cpu_wait_n = !pend_valid_q;
    assign spi_cs_n   = busy ? !(in_xfer || state == S_HOLD) : cpu_cs_n;
    assign xfer_start = busy ? seq_start_q : (cpu_xfer_req || pend_fire_q);
    assign xfer_tx    = busy ? seq_tx_q : (pend_fire_q ? pend_tx_q : cpu_tx);

endmodule

// File: tb/tb_flash_read_sequencer.sv
// Scoreboard bench for flash_read_sequencer: a behavioural SPI engine and
// consumer, expected-value queues, and monitors that pop on DUT activity.
module tb_flash_read_sequencer;

    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, data_ack = 1'b0;
    logic [23:0] flash_addr = '0;
    logic [15:0] len = '0;
    logic        cpu_cs_n = 1'b1, cpu_xfer_req = 1'b0, xfer_done = 1'b0;
    logic [7:0]  cpu_tx = 8'hFF, xfer_rx = '0;
    logic        busy, done, aborted, data_valid, cpu_wait_n, spi_cs_n, xfer_start;
    logic [7:0]  data_out, xfer_tx;

    flash_read_sequencer #(.READ_CMD(8'h03), .CS_GAP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .flash_addr(flash_addr), .len(len),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted),
        .data_out(data_out), .data_valid(data_valid), .data_ack(data_ack),
        .cpu_cs_n(cpu_cs_n), .cpu_xfer_req(cpu_xfer_req), .cpu_tx(cpu_tx),
        .cpu_wait_n(cpu_wait_n), .spi_cs_n(spi_cs_n), .xfer_start(xfer_start),
        .xfer_tx(xfer_tx), .xfer_done(xfer_done), .xfer_rx(xfer_rx)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    int cyc = 0, start_cnt = 0, done_cnt = 0;
    int last_start_cyc = 0, busy_fall_cyc = 0, last_hold_len = 0;
    logic last_start_cs = 1'b1;
    int hold_cnt = 0, eng_cnt = 0;

    logic [7:0] exp_tx[$], exp_data[$], rx_q[$];
    logic       exp_ab[$];
    int         exp_gap[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    always @(posedge clk) cyc++;

    // SPI byte engine: answers each xfer_start with xfer_done three cycles later
    always @(negedge clk) begin
        xfer_done = 1'b0;
        if (rst) begin
            eng_cnt = 0;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                xfer_rx   = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
                xfer_done = 1'b1;
            end
        end else if (xfer_start) begin
            eng_cnt = 3;
        end
    end

    always @(negedge clk) begin
        if (data_valid && !rst) begin
            if (hold_cnt > 0) begin hold_cnt--; data_ack = 1'b0; end
            else data_ack = 1'b1;
        end else begin
            data_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (xfer_start && !rst) begin
            start_cnt++;
            last_start_cyc = cyc;
            last_start_cs  = spi_cs_n;
            if (exp_tx.size() == 0) check("unexpected_xfer_start", 1, 0);
            else check("xfer_tx", xfer_tx, exp_tx.pop_front());
            if (busy) check("start_while_valid", data_valid, 0);
        end
    end

    logic       prev_dv = 1'b0;
    logic [7:0] cur_exp = '0;
    int         hold_len = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_dv = 1'b0; hold_len = 0;
        end else begin
            if (data_valid) begin
                if (!prev_dv) begin
                    hold_len = 0;
                    if (exp_data.size() == 0) begin check("unexpected_data", 1, 0); cur_exp = '0; end
                    else cur_exp = exp_data.pop_front();
                end
                hold_len++;
                check("data_out", data_out, cur_exp);
            end else if (prev_dv) begin
                last_hold_len = hold_len;
            end
            prev_dv = data_valid;
        end
    end

    always @(negedge clk) begin
        if (done && !rst) begin
            done_cnt++;
            if (exp_ab.size() == 0) check("unexpected_done", 1, 0);
            else check("aborted", aborted, exp_ab.pop_front());
        end
    end

    // Counts busy cycles with CS high; a clean burst shows exactly the CS gap
    logic prev_busy = 1'b0;
    int   hi_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0; hi_cnt = 0;
        end else begin
            if (busy && spi_cs_n) hi_cnt++;
            if (prev_busy && !busy) begin
                busy_fall_cyc = cyc;
                if (exp_gap.size() == 0) check("unexpected_busy_end", 1, 0);
                else check("cs_high_cycles", hi_cnt, exp_gap.pop_front());
                hi_cnt = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic pulse_start(input logic [23:0] a, input logic [15:0] n);
        flash_addr = a; len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_read(input logic [23:0] a, input int ndata);
        exp_tx.push_back(8'h03);
        exp_tx.push_back(a[23:16]);
        exp_tx.push_back(a[15:8]);
        exp_tx.push_back(a[7:0]);
        for (int i = 0; i < ndata; i++) exp_tx.push_back(8'hFF);
    endtask

    task automatic wait_starts(input int target, input string nm);
        for (int i = 0; i < 200; i++) begin
            if (start_cnt >= target) return;
            @(negedge clk);
        end
        check(nm, 0, 1);
    endtask

    task automatic wait_done(input string nm);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_cnt > d0) return;
        end
        check(nm, 0, 1);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 50; i++) begin
            if (!busy) begin repeat (2) @(negedge clk); return; end
            @(negedge clk);
        end
        check(nm, 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_spi_cs_n"}, spi_cs_n, 1);
        check({tag, "_xfer_start"}, xfer_start, 0);
        check({tag, "_xfer_tx"}, xfer_tx, 8'hFF);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_aborted"}, aborted, 0);
        check({tag, "_data_valid"}, data_valid, 0);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_cpu_wait_n"}, cpu_wait_n, 1);
    endtask

    int base;

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic read
        push_read(24'h012345, 3);
        rx_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        exp_data = '{8'hAA, 8'hBB, 8'hCC};
        exp_ab.push_back(1'b0); exp_gap.push_back(4);
        pulse_start(24'h012345, 16'd3);
        check("accept_busy", busy, 1);
        check("accept_cs_low", spi_cs_n, 0);
        check("accept_first_start", xfer_start, 1);
        wait_done("basic_done_timeout");
        wait_idle("basic_idle_timeout");

        // Backpressure on byte 1
        hold_cnt = 10;
        push_read(24'hABCDEF, 2);
        rx_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        exp_data = '{8'h11, 8'h22};
        exp_ab.push_back(1'b0); exp_gap.push_back(4);
        base = start_cnt;
        pulse_start(24'hABCDEF, 16'd2);
        wait_starts(base + 6, "bp_second_byte_timeout");
        check("bp_hold_len", last_hold_len, 11);
        wait_done("bp_done_timeout");
        wait_idle("bp_idle_timeout");

        // Zero-length request
        exp_ab.push_back(1'b0); exp_gap.push_back(1);
        base = start_cnt;
        pulse_start(24'h000100, 16'd0);
        check("len0_busy", busy, 1);
        check("len0_done", done, 1);
        check("len0_cs", spi_cs_n, 1);
        @(negedge clk);
        check("len0_busy_fall", busy, 0);
        check("len0_done_fall", done, 0);
        check("len0_no_start", start_cnt, base);
        repeat (3) @(negedge clk);

        // Abort during A1
        exp_tx = '{8'h03, 8'h12, 8'h34};
        exp_ab.push_back(1'b1); exp_gap.push_back(4);
        base = start_cnt;
        pulse_start(24'h123456, 16'd4);
        wait_starts(base + 3, "abort_a1_timeout");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("abort_a1_done_timeout");
        wait_idle("abort_a1_idle_timeout");
        check("abort_a1_cs_after", spi_cs_n, 1);
        check("aborted_held", aborted, 1);
        check("abort_a1_start_count", start_cnt, base + 3);

        // Abort during HOLD
        hold_cnt = 1000;
        push_read(24'h00ABCD, 1);
        rx_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h77};
        exp_data = '{8'h77};
        exp_ab.push_back(1'b1); exp_gap.push_back(4);
        pulse_start(24'h00ABCD, 16'd2);
        for (int i = 0; i < 200 && !data_valid; i++) @(negedge clk);
        check("hold_reached", data_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("hold_abort_dv_drop", data_valid, 0);
        hold_cnt = 0;
        wait_done("abort_hold_done_timeout");
        wait_idle("abort_hold_idle_timeout");

        // CPU contention
        push_read(24'h000010, 1);
        exp_tx.push_back(8'h9F);
        rx_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h5A};
        exp_data = '{8'h5A};
        exp_ab.push_back(1'b0); exp_gap.push_back(4);
        base = start_cnt;
        pulse_start(24'h000010, 16'd1);
        check("aborted_cleared_on_accept", aborted, 0);
        wait_starts(base + 2, "cpu_mid_timeout");
        cpu_cs_n = 1'b0; cpu_tx = 8'h9F; cpu_xfer_req = 1'b1;
        @(negedge clk);
        cpu_xfer_req = 1'b0; cpu_tx = 8'hFF;
        check("cpu_wait_low", cpu_wait_n, 0);
        wait_done("cpu_done_timeout");
        check("cpu_wait_at_done", cpu_wait_n, 0);
        wait_starts(base + 6, "cpu_replay_timeout");
        check("cpu_replay_delay", last_start_cyc - busy_fall_cyc, 1);
        check("cpu_replay_cs", last_start_cs, 0);
        for (int i = 0; i < 20 && !cpu_wait_n; i++) begin
            check("cpu_wait_until_done", xfer_done, 0);
            @(negedge clk);
        end
        check("cpu_wait_released", cpu_wait_n, 1);
        repeat (2) @(negedge clk);

        // Start dropped while CPU holds CS
        pulse_start(24'h000200, 16'd1);
        check("drop_busy0", busy, 0);
        repeat (2) @(negedge clk);
        check("drop_busy2", busy, 0);
        cpu_cs_n = 1'b1;
        repeat (2) @(negedge clk);

        // Async reset mid-DATA, then a clean burst
        push_read(24'h0F0F0F, 3);
        base = start_cnt;
        pulse_start(24'h0F0F0F, 16'd3);
        wait_starts(base + 5, "rst_data_timeout");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        exp_tx.delete(); exp_data.delete(); rx_q.delete(); exp_ab.delete(); exp_gap.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        push_read(24'h345678, 1);
        rx_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hE1};
        exp_data = '{8'hE1};
        exp_ab.push_back(1'b0); exp_gap.push_back(4);
        pulse_start(24'h345678, 16'd1);
        wait_done("post_rst_done_timeout");
        wait_idle("post_rst_idle_timeout");

        repeat (5) @(negedge clk);
        check("leftover_tx", exp_tx.size(), 0);
        check("leftover_data", exp_data.size(), 0);
        check("leftover_done", exp_ab.size(), 0);
        check("leftover_gap", exp_gap.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/flash_read_sequencer.md
# flash_read_sequencer

Hardware read engine and bus owner for the shared flash/SD SPI byte engine. It autonomously issues a flash READ command (opcode, 24-bit address, N data bytes) and streams the bytes to a consumer over a valid/ack handshake. While it runs, it arbitrates the CPU's register-driven SPI accesses: CPU byte transfers are held off with `cpu_wait_n` and replayed afterwards. It sits between the ZX-Uno register decode (CPU side) and the single SPI shift engine that drives the flash and SD pins.

## Interface
- `READ_CMD`, 8'h03: opcode sent as the first byte.
- `CS_GAP`, 4: minimum clk cycles `spi_cs_n` stays high after a sequence ends (range 1..15).
- `clk` in 1: system clock; everything is registered on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request pulse.
- `flash_addr` in 24: start address, sampled on accept.
- `len` in 16: data byte count, sampled on accept.
- `abort` in 1: one-cycle pulse; ends a running sequence early.
- `busy` out 1: high from accept until the end of the CS gap.
- `done` out 1: one-cycle pulse when the sequence ends.
- `aborted` out 1: level, valid with `done`, held until the next accept.
- `data_out` out 8: received data byte.
- `data_valid` out 1: `data_out` is valid.
- `data_ack` in 1: consumer accepts the byte.
- `cpu_cs_n` in 1: CPU-requested flash CS level, from the register.
- `cpu_xfer_req` in 1: CPU byte-transfer pulse.
- `cpu_tx` in 8: CPU byte to send.
- `cpu_wait_n` out 1: low while a CPU request is held off.
- `spi_cs_n` out 1: flash CS to the pin.
- `xfer_start` out 1: one-cycle start pulse to the SPI byte engine.
- `xfer_tx` out 8: byte to the engine.
- `xfer_done` in 1: one-cycle pulse from the engine; `xfer_rx` is valid with it.
- `xfer_rx` in 8: byte received by the engine.

## Operation
- **States:** IDLE, CMD, A2, A1, A0, DATA, HOLD, GAP.
- **Accept:** `start` is accepted only in IDLE, with `cpu_cs_n`=1 and no CPU request pending. Otherwise `start` is dropped; `busy` stays 0.
- **Accept with `len`=0:** no SPI activity. `done` pulses the next cycle with `aborted`=0, and `busy` is high for that one cycle.
- **Command phase:** `xfer_tx` sequence is `READ_CMD`, `addr[23:16]`, `addr[15:8]`, `addr[7:0]`. Each `xfer_start` is issued the cycle after the previous `xfer_done`.
- **Data phase:** DATA sends 8'hFF.
  - On `xfer_done`, `data_out` ← `xfer_rx`, `data_valid` ← 1, and the state moves to HOLD.
  - In HOLD, `data_valid` and `data_out` stay stable until `data_ack` is sampled high. `data_valid` drops the next cycle.
  - The remaining count (16-bit) is decremented on ack. If it is nonzero, the next `xfer_start` is issued in the same cycle `data_valid` drops. If it is zero, the state moves to GAP.
- **GAP:** `spi_cs_n`=1 for `CS_GAP` cycles. `done` pulses in the last GAP cycle, and `busy` falls in the following cycle.
- **Abort:**
  - In CMD/A*/DATA, `abort` is latched; the in-flight byte completes (`xfer_done`), no further `xfer_start` is issued, and received data is discarded.
  - In HOLD, `abort` clears `data_valid` immediately (next cycle).
  - In both cases the state moves to GAP and `done` pulses with `aborted`=1.
  - In IDLE or GAP, `abort` is ignored.
- **Mux:** while `busy`=1, `spi_cs_n`, `xfer_start` and `xfer_tx` come from the sequencer. Otherwise they pass through `cpu_cs_n`, `cpu_xfer_req` and `cpu_tx`, combinationally.
- **CPU during busy:**
  - A `cpu_xfer_req` during busy latches `cpu_tx` into a single pending slot and drives `cpu_wait_n`=0.
  - The pending transfer is issued one cycle after `busy` falls, with `spi_cs_n` following `cpu_cs_n`.
  - `cpu_wait_n` returns to 1 with that transfer's `xfer_done`.
  - A second request while one is pending overwrites the slot (CPU is stalled, so this cannot happen in the system).
- **`xfer_done` outside an expected window:** ignored.

## Timing
- **Reset values:** `spi_cs_n`=1, `xfer_start`=0, `xfer_tx`=8'hFF, `busy`=0, `done`=0, `aborted`=0, `data_valid`=0, `data_out`=0, `cpu_wait_n`=1, state IDLE, pending slot empty. Reset mid-sequence forces these immediately (asynchronously); a partially shifted byte is abandoned.
- **Accept in cycle T:** `busy`=1 and `spi_cs_n`=0 at T+1, and the first `xfer_start` (`READ_CMD`) at T+1.
- **Per-byte overhead:** one cycle between `xfer_done` and the next `xfer_start`, plus the ack latency in the data phase.
- **`done` to restart:** `start` can be accepted the cycle after `busy` falls.

## Test plan
- **Basic read:** `start`, addr 24'h012345, `len`=3, engine returns AA/BB/CC, consumer acks immediately. Required: `xfer_tx` = 03,01,23,45,FF,FF,FF; `data_out` = AA,BB,CC; `done` once with `aborted`=0; `spi_cs_n` low throughout and high for 4 cycles after.
- **Backpressure:** `len`=2, withhold `data_ack` for 10 cycles on byte 1. Required: `data_valid` and `data_out` stable all 10 cycles, no `xfer_start` until the cycle valid drops.
- **`len`=0:** Required: `done` at T+1, `spi_cs_n` never low, zero `xfer_start`.
- **Abort:**
  - During A1: A0 is never sent, `done` with `aborted`=1, `spi_cs_n` high afterwards.
  - During HOLD: `data_valid` drops the next cycle.
- **CPU contention:** `cpu_xfer_req` with `cpu_tx`=9F mid-sequence. Required: `cpu_wait_n`=0 until the sequence ends; 9F is issued one cycle after `busy` falls; `cpu_wait_n`=1 on its `xfer_done`. Also: `start` while `cpu_cs_n`=0 is dropped (`busy` stays 0).
- **Async reset mid-DATA:** Required: all outputs at reset values immediately, a fresh `start` then completes normally.
